// File: rtl/fft_pkg.sv
// Shared FFT definitions: pairing-stage FSM encoding and butterfly pipeline depth.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PAIR = 2'd2
   } fft_feed_state_e;

   // Input-register plus multiply-register stages inside fft_complex_compute.
   localparam int unsigned FFT_BFLY_LATENCY = 2;

endpackage

// File: rtl/fft_butterfly_feeder_if.sv
// Sample-in / pair-out bus between the sample source, the feeder and the butterfly.
interface fft_butterfly_feeder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SPAN       = 8
);
   import fft_pkg::*;

   localparam int unsigned AW = $clog2(SPAN);

   logic                  in_valid;
   logic                  in_sof;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  tw_we;
   logic [AW-1:0]         tw_addr;
   logic [DATA_WIDTH-1:0] tw_data;
   logic [DATA_WIDTH-1:0] x_N;
   logic [DATA_WIDTH-1:0] x_M;
   logic [DATA_WIDTH-1:0] w_N;
   logic                  out_valid;
   logic                  out_last;
   logic                  y_valid;
   logic                  y_last;
   logic                  err_sync;

   modport master (
      output in_valid, in_sof, in_data, tw_we, tw_addr, tw_data,
      input  x_N, x_M, w_N, out_valid, out_last, y_valid, y_last, err_sync
   );

   modport slave (
      input  in_valid, in_sof, in_data, tw_we, tw_addr, tw_data,
      output x_N, x_M, w_N, out_valid, out_last, y_valid, y_last, err_sync
   );

endinterface

// File: rtl/fft_twiddle_ram.sv
// Twiddle table: SPAN x DATA_WIDTH, synchronous write, registered read (old data on collision).
module fft_twiddle_ram
   import fft_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SPAN       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [$clog2(SPAN)-1:0]       waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          re,
   input  logic [$clog2(SPAN)-1:0]       raddr,
   output logic [DATA_WIDTH-1:0]         rdata
);

   logic [DATA_WIDTH-1:0] mem_q [SPAN];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   // Read register holds its value when no read is requested.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Storage is not reset; it is loaded by software before use.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_butterfly_feeder.sv
// Radix-2 DIF pairing stage: buffers the first SPAN samples of a group and emits
// (buffered, incoming, twiddle) pairs with valid/last sideband for the butterfly.
module fft_butterfly_feeder
   import fft_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SPAN       = 8
) (
   input logic                  clk,
   input logic                  rst,
   fft_butterfly_feeder_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(SPAN);
   localparam int unsigned LAT   = FFT_BFLY_LATENCY;

   fft_feed_state_e       state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] x_n_q, x_n_d;
   logic [DATA_WIDTH-1:0] x_m_q, x_m_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  err_sync_q, err_sync_d;
   logic [LAT-1:0]        yv_q, yv_d;
   logic [LAT-1:0]        yl_q, yl_d;

   logic [DATA_WIDTH-1:0] sbuf_q [SPAN];
   logic                  sbuf_we;
   logic [CNT_W-1:0]      sbuf_waddr;
   logic                  tw_re;
   logic                  resync;
   logic                  cnt_last;
   logic [DATA_WIDTH-1:0] tw_rdata;

   assign cnt_last = (cnt_q == CNT_W'(SPAN - 1));

   // A start-of-frame anywhere past the first slot of a group restarts the group.
   assign resync = bus.in_valid && bus.in_sof &&
                   (((state_q == FILL) && (cnt_q != '0)) || (state_q == PAIR));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_n_d       = x_n_q;
      x_m_d       = x_m_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      err_sync_d  = 1'b0;
      sbuf_we     = 1'b0;
      sbuf_waddr  = cnt_q;
      tw_re       = 1'b0;

      if (resync) begin
         err_sync_d = 1'b1;
         sbuf_we    = 1'b1;
         sbuf_waddr = '0;
         cnt_d      = CNT_W'(1);
         state_d    = FILL;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid && bus.in_sof) begin
                  sbuf_we    = 1'b1;
                  sbuf_waddr = '0;
                  cnt_d      = CNT_W'(1);
                  state_d    = FILL;
               end
            end
            FILL: begin
               if (bus.in_valid) begin
                  sbuf_we = 1'b1;
                  if (cnt_last) begin
                     cnt_d   = '0;
                     state_d = PAIR;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            PAIR: begin
               if (bus.in_valid) begin
                  x_n_d       = sbuf_q[cnt_q];
                  x_m_d       = bus.in_data;
                  tw_re       = 1'b1;
                  out_valid_d = 1'b1;
                  out_last_d  = cnt_last;
                  if (cnt_last) begin
                     cnt_d   = '0;
                     state_d = FILL;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Sideband delay matching the butterfly's output latency.
   always_comb begin
      yv_d[0] = out_valid_q;
      yl_d[0] = out_last_q;
      for (int unsigned i = 1; i < LAT; i++) begin
         yv_d[i] = yv_q[i-1];
         yl_d[i] = yl_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_n_q       <= '0;
         x_m_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_sync_q  <= 1'b0;
         yv_q        <= '0;
         yl_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_n_q       <= x_n_d;
         x_m_q       <= x_m_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_sync_q  <= err_sync_d;
         yv_q        <= yv_d;
         yl_q        <= yl_d;
      end
   end

   // First-half sample buffer; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (sbuf_we) begin
         sbuf_q[sbuf_waddr] <= bus.in_data;
      end
   end

   fft_twiddle_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .SPAN       (SPAN)
   ) u_twiddle_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.tw_we),
      .waddr (bus.tw_addr),
      .wdata (bus.tw_data),
      .re    (tw_re),
      .raddr (cnt_q),
      .rdata (tw_rdata)
   );

   assign bus.x_N       = x_n_q;
   assign bus.x_M       = x_m_q;
   assign bus.w_N       = tw_rdata;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.err_sync  = err_sync_q;
   assign bus.y_valid   = yv_q[LAT-1];
   assign bus.y_last    = yl_q[LAT-1];

endmodule

// File: tb/tb_fft_butterfly_feeder.sv
// Bench for fft_butterfly_feeder: directed scenarios plus random traffic against a
// queue-based group model of the pairing rules.
module tb_fft_butterfly_feeder;
   import fft_pkg::*;

   localparam int unsigned DW   = 32;
   localparam int unsigned SPAN = 8;
   localparam int unsigned AW   = $clog2(SPAN);

   logic clk;
   logic rst;

   fft_butterfly_feeder_if #(.DATA_WIDTH(DW), .SPAN(SPAN)) bus ();

   fft_butterfly_feeder #(
      .DATA_WIDTH (DW),
      .SPAN       (SPAN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Reference model state: samples of the group in progress, and whether a group has started.
   logic [DW-1:0] grp[$];
   bit            synced;
   logic [DW-1:0] tw_m [SPAN];

   logic [DW-1:0] e_x, e_m, e_w;
   logic          e_ov, e_ol, e_err, e_yv, e_yl;
   logic          ov_prev, ol_prev;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Drive one cycle, predict the registered outputs, then compare after the edge.
   task automatic cyc(input bit v, input bit s, input logic [DW-1:0] d,
                      input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit r);
      int pos;
      int k;
      bus.in_valid = v;
      bus.in_sof   = s;
      bus.in_data  = d;
      bus.tw_we    = we;
      bus.tw_addr  = wa;
      bus.tw_data  = wd;
      rst          = r;

      if (r) begin
         e_x = '0; e_m = '0; e_w = '0;
         e_ov = 0; e_ol = 0; e_err = 0; e_yv = 0; e_yl = 0;
         ov_prev = 0; ol_prev = 0;
         grp.delete();
         synced = 0;
      end else begin
         e_yv = ov_prev;
         e_yl = ol_prev;
         ov_prev = e_ov;
         ol_prev = e_ol;
         e_ov = 0; e_ol = 0; e_err = 0;
         if (v) begin
            pos = grp.size();
            if (!synced) begin
               if (s) begin
                  grp.delete();
                  grp.push_back(d);
                  synced = 1;
               end
            end else if (s && pos != 0) begin
               e_err = 1;
               grp.delete();
               grp.push_back(d);
            end else if (pos < int'(SPAN)) begin
               grp.push_back(d);
            end else begin
               k = pos - int'(SPAN);
               e_x  = grp[k];
               e_m  = d;
               e_w  = tw_m[k];
               e_ov = 1;
               e_ol = (k == int'(SPAN) - 1);
               if (e_ol) grp.delete();
               else grp.push_back(d);
            end
         end
         if (we) tw_m[wa] = wd;
      end

      @(posedge clk);
      #1;
      chk("out_valid", DW'(bus.out_valid), DW'(e_ov));
      chk("out_last",  DW'(bus.out_last),  DW'(e_ol));
      chk("err_sync",  DW'(bus.err_sync),  DW'(e_err));
      chk("y_valid",   DW'(bus.y_valid),   DW'(e_yv));
      chk("y_last",    DW'(bus.y_last),    DW'(e_yl));
      chk("x_N", bus.x_N, e_x);
      chk("x_M", bus.x_M, e_m);
      chk("w_N", bus.w_N, e_w);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, '0, 0);
   endtask

   task automatic sample(input int val, input bit s);
      cyc(1, s, DW'(val), 0, '0, '0, 0);
   endtask

   initial begin
      bit v, s, r, we;
      ov_prev = 0; ol_prev = 0; synced = 0;
      e_ov = 0; e_ol = 0; e_err = 0; e_yv = 0; e_yl = 0;
      e_x = '0; e_m = '0; e_w = '0;

      cyc(0, 0, '0, 0, '0, '0, 1);
      cyc(0, 0, '0, 0, '0, '0, 1);
      idle(2);

      // Twiddle table load.
      for (int k = 0; k < int'(SPAN); k++) cyc(0, 0, '0, 1, AW'(k), DW'(100 + k), 0);
      idle(1);

      // One group, continuous.
      for (int i = 1; i <= 16; i++) sample(i, i == 1);
      idle(4);

      // One group with a bubble after every sample.
      for (int i = 1; i <= 16; i++) begin
         sample(i, i == 1);
         idle(1);
      end
      idle(3);

      // Two back-to-back groups, start-of-frame only on the first.
      for (int i = 1; i <= 32; i++) sample(i, i == 1);
      idle(3);

      // Resync in the pairing half.
      for (int i = 1; i <= 26; i++) sample(i, (i == 1) || (i == 11));
      idle(3);

      // Reset mid-group, then unsynchronised samples are ignored.
      for (int i = 1; i <= 10; i++) sample(i, i == 1);
      cyc(0, 0, '0, 0, '0, '0, 1);
      for (int i = 20; i <= 30; i++) sample(i, 0);
      idle(3);

      // Twiddle write colliding with its own read, then the new value in the next group.
      for (int i = 1; i <= 32; i++) begin
         if (i == 12) cyc(1, 0, DW'(i), 1, AW'(3), DW'(55), 0);
         else sample(i, i == 1);
      end
      idle(3);

      // Random traffic with occasional resyncs, resets and table rewrites.
      for (int n = 0; n < 3000; n++) begin
         v  = ($urandom_range(0, 99) < 75);
         s  = synced ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 30);
         r  = ($urandom_range(0, 999) < 3);
         we = !r && ($urandom_range(0, 99) < 10);
         cyc(v, s, DW'($urandom), we, AW'($urandom_range(0, SPAN - 1)), DW'($urandom), r);
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
